// File: rtl/custom_down_ring_counter_pkg.sv
// Shared types and constants for the programmable down-counting ring counter.
// Holds the state encoding, default width and the all-zero count constant.
package custom_down_ring_counter_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

endpackage

// File: rtl/custom_down_ring_counter_dec.sv
// Structural WIDTH-bit subtract-one: a + all-ones, carry-out dropped.
// Ports: a (operand), y (a - 1 modulo 2^WIDTH).
module down_decrement_by_one_module
    import custom_down_ring_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] c;

    assign c[0] = 1'b0;

    // Full adder with b tied to 1: sum = ~(a ^ c), carry = a | c.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign y[i] = ~(a[i] ^ c[i]);
            if (i < WIDTH - 1) begin : g_carry
                assign c[i+1] = a[i] | c[i];
            end
        end
    endgenerate

endmodule

// File: rtl/custom_down_ring_counter.sv
// Down-counting ring counter: loads N on start, counts N..0, pulses done.
// Ports: clk, rst (sync, active-high), en, start_i, stop_i, auto_reload_i,
//        i_num_cnt (N), cnt_o (count), busy_o (RUN), done_o (zero pulse).
module custom_down_ring_counter
    import custom_down_ring_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    input  logic [WIDTH-1:0] i_num_cnt,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] cnt_dec;
    logic             mode_reg;
    logic             cnt_zero;
    logic             run;

    down_decrement_by_one_module #(
        .WIDTH(WIDTH)
    ) u_dec (
        .a(cnt),
        .y(cnt_dec)
    );

    assign cnt_zero = (cnt == {WIDTH{1'b0}});
    assign run      = (state == ST_RUN);

    assign cnt_o  = cnt;
    assign busy_o = run;
    // Deliberately independent of start/stop so a pending zero is never lost.
    assign done_o = run & en & cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= {WIDTH{1'b0}};
            reload_reg <= {WIDTH{1'b0}};
            mode_reg   <= 1'b0;
        end else if (stop_i) begin
            state <= ST_IDLE;
            cnt   <= {WIDTH{1'b0}};
        end else if (start_i) begin
            state      <= ST_RUN;
            cnt        <= i_num_cnt;
            reload_reg <= i_num_cnt;
            mode_reg   <= auto_reload_i;
        end else if (run && en) begin
            if (!cnt_zero) begin
                cnt <= cnt_dec;
            end else if (mode_reg) begin
                cnt <= reload_reg;
            end else begin
                state <= ST_IDLE;
                cnt   <= {WIDTH{1'b0}};
            end
        end
    end

endmodule
